// File: rtl/eq_run_detector.sv
// eq_run_detector
// ---------------
// Watches a stream of qualified equality results and decides when the stream
// has "locked": RUN_LEN consecutive matches move SEARCH -> LOCKED, and
// MISS_TOL consecutive mismatches while locked move LOCKED -> SEARCH.
// Every output is a register, so the response to a sample appears the cycle
// after the edge that samples it.
//
// Sample qualification: eq is consumed only on cycles where valid is high.
// There is no backpressure; a cycle with valid low is ignored and leaves
// the state and counters as they are.
//
// Parameters
//   RUN_LEN   consecutive matches needed to lock           (1..15)
//   MISS_TOL  consecutive misses while locked to unlock     (1..15)
//
// Ports
//   clk           in   single clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   valid         in   qualifies eq this cycle
//   eq            in   equality result from the upstream comparator
//   clear         in   synchronous restart to SEARCH (beats valid/eq)
//   locked        out  high while in LOCKED (this is the FSM state)
//   lock_pulse    out  one cycle on SEARCH -> LOCKED
//   unlock_pulse  out  one cycle on LOCKED -> SEARCH (never on clear)
//   run_cnt       out  consecutive-match count while searching
//   miss_cnt      out  consecutive-mismatch count while locked
//   match_total   out  16-bit saturating count of valid&eq cycles
//                      (present only when EQ_RUN_STATS_EN is defined)
//
// Optional feature macro: EQ_RUN_STATS_EN

module eq_run_detector #(
  parameter int RUN_LEN  = 4,
  parameter int MISS_TOL = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        eq,
  input  logic        clear,
  output logic        locked,
  output logic        lock_pulse,
  output logic        unlock_pulse,
  output logic [3:0]  run_cnt,
  output logic [3:0]  miss_cnt
`ifdef EQ_RUN_STATS_EN
  ,
  output logic [15:0] match_total
`endif
);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Counter values at which the next qualifying sample completes a run/miss.
  localparam logic [3:0] RUN_LAST  = 4'(RUN_LEN - 1);
  localparam logic [3:0] MISS_LAST = 4'(MISS_TOL - 1);

  logic [0:0] state_q, state_d;
  logic [3:0] run_cnt_q, run_cnt_d;
  logic [3:0] miss_cnt_q, miss_cnt_d;
  logic       lock_pulse_q, lock_pulse_d;
  logic       unlock_pulse_q, unlock_pulse_d;

  always_comb begin
    state_d        = state_q;
    run_cnt_d      = run_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    lock_pulse_d   = 1'b0;
    unlock_pulse_d = 1'b0;

    if (clear) begin
      // Restart silently: no unlock_pulse even if we were locked.
      state_d    = ST_SEARCH;
      run_cnt_d  = 4'd0;
      miss_cnt_d = 4'd0;
    end else if (valid) begin
      case (state_q)
        ST_SEARCH: begin
          if (eq) begin
            if (run_cnt_q == RUN_LAST) begin
              state_d      = ST_LOCKED;
              run_cnt_d    = 4'd0;
              miss_cnt_d   = 4'd0;
              lock_pulse_d = 1'b1;
            end else begin
              run_cnt_d = run_cnt_q + 4'd1;
            end
          end else begin
            run_cnt_d = 4'd0;
          end
        end
        default: begin // ST_LOCKED
          if (eq) begin
            miss_cnt_d = 4'd0;
          end else if (miss_cnt_q == MISS_LAST) begin
            // The unlocking miss is consumed here and does not seed a new run.
            state_d        = ST_SEARCH;
            run_cnt_d      = 4'd0;
            miss_cnt_d     = 4'd0;
            unlock_pulse_d = 1'b1;
          end else begin
            miss_cnt_d = miss_cnt_q + 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_SEARCH;
      run_cnt_q      <= 4'd0;
      miss_cnt_q     <= 4'd0;
      lock_pulse_q   <= 1'b0;
      unlock_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      run_cnt_q      <= run_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
      lock_pulse_q   <= lock_pulse_d;
      unlock_pulse_q <= unlock_pulse_d;
    end
  end

  assign locked       = (state_q == ST_LOCKED);
  assign lock_pulse   = lock_pulse_q;
  assign unlock_pulse = unlock_pulse_q;
  assign run_cnt      = run_cnt_q;
  assign miss_cnt     = miss_cnt_q;

`ifdef EQ_RUN_STATS_EN
  logic [15:0] match_total_q, match_total_d;

  always_comb begin
    match_total_d = match_total_q;
    if (clear) begin
      match_total_d = 16'd0;
    end else if (valid && eq && (match_total_q != 16'hFFFF)) begin
      match_total_d = match_total_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_total_q <= 16'd0;
    end else begin
      match_total_q <= match_total_d;
    end
  end

  assign match_total = match_total_q;
`endif

endmodule
